// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Turns command bytes from the UART receiver into one-hot virtual button
// pulses for the watch main controller. Each press is stretched to
// PULSE_CYCLES, followed by GAP_CYCLES of all-zero output. One further press
// can wait in a pending slot. Unknown bytes and dropped presses are flagged.
// Optional build macro: UART_CMD_LOWERCASE_EN folds ASCII lowercase letters to
// uppercase before the key match.
module uart_cmd_decoder #(
    parameter int                   N_BTN        = 4,
    parameter logic [N_BTN*8-1:0]   KEY_MAP      = 32'h55444C52,
    parameter int                   PULSE_CYCLES = 1,
    parameter int                   GAP_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic [N_BTN-1:0] o_btn,
    output logic             o_busy,
    output logic             o_unknown,
    output logic             o_overflow
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0]    PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0]    GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [N_BTN-1:0] ONE_BTN    = N_BTN'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [N_BTN-1:0] btn_reg, btn_next;
    logic             pend_valid_reg, pend_valid_next;
    logic [N_BTN-1:0] pend_btn_reg, pend_btn_next;
    logic             unknown_reg, unknown_next;
    logic             overflow_reg, overflow_next;

    logic [7:0]       key_byte;
    logic [N_BTN-1:0] hit;
    logic [N_BTN-1:0] match_btn;
    logic             accept;
    logic             acc_hit;
    logic             acc_miss;
    logic             launch_pend;

`ifdef UART_CMD_LOWERCASE_EN
    // 'a'..'z' are matched as 'A'..'Z'; everything else passes through
    assign key_byte = ((rx_data >= 8'h61) && (rx_data <= 8'h7A)) ? (rx_data - 8'h20) : rx_data;
`else
    assign key_byte = rx_data;
`endif

    // One comparator per button against its key in the map
    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_key_cmp
            assign hit[gi] = (key_byte == KEY_MAP[8*gi +: 8]);
        end
    endgenerate

    // Priority select: scanning downwards lets the lowest matching index win
    always_comb begin
        match_btn = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match_btn = ONE_BTN << i;
            end
        end
    end

    assign accept      = rx_done & sel;
    assign acc_hit     = accept & (|hit);
    assign acc_miss    = accept & ~(|hit);
    // A queued press is only honoured while the decoder is still selected
    assign launch_pend = pend_valid_reg & sel;

    // Next-state logic: pulse/gap sequencing, pending slot and status flags
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        btn_next        = btn_reg;
        pend_valid_next = pend_valid_reg & sel;
        pend_btn_next   = pend_btn_reg;
        unknown_next    = acc_miss;
        overflow_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                btn_next = '0;
                if (acc_hit) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LOAD;
                    btn_next   = match_btn;
                end
            end

            PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                    btn_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
                if (acc_hit) begin
                    if (!pend_valid_reg) begin
                        pend_valid_next = 1'b1;
                        pend_btn_next   = match_btn;
                    end else begin
                        overflow_next = 1'b1;
                    end
                end
            end

            GAP: begin
                btn_next = '0;
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                    if (acc_hit) begin
                        if (!pend_valid_reg) begin
                            pend_valid_next = 1'b1;
                            pend_btn_next   = match_btn;
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end
                end else if (launch_pend) begin
                    // Gap over: fire the queued press, a simultaneous one takes its slot
                    state_next      = PULSE;
                    cnt_next        = PULSE_LOAD;
                    btn_next        = pend_btn_reg;
                    pend_valid_next = acc_hit;
                    if (acc_hit) begin
                        pend_btn_next = match_btn;
                    end
                end else if (acc_hit) begin
                    // Press arriving on the last gap cycle fires directly, as from IDLE
                    state_next = PULSE;
                    cnt_next   = PULSE_LOAD;
                    btn_next   = match_btn;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next      = IDLE;
                cnt_next        = '0;
                btn_next        = '0;
                pend_valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously when rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            btn_reg        <= '0;
            pend_valid_reg <= 1'b0;
            pend_btn_reg   <= '0;
            unknown_reg    <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            btn_reg        <= btn_next;
            pend_valid_reg <= pend_valid_next;
            pend_btn_reg   <= pend_btn_next;
            unknown_reg    <= unknown_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign o_btn      = btn_reg;
    assign o_busy     = (state_reg != IDLE);
    assign o_unknown  = unknown_reg;
    assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder. Two instances share the stimulus:
// dut_a uses the default 1/1 timing, dut_b uses PULSE_CYCLES=4, GAP_CYCLES=2.
module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [7:0] rx_data;
    logic       rx_done;

    logic [3:0] a_btn, b_btn;
    logic       a_busy, b_busy;
    logic       a_unknown, b_unknown;
    logic       a_overflow, b_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder dut_a (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .o_btn      (a_btn),
        .o_busy     (a_busy),
        .o_unknown  (a_unknown),
        .o_overflow (a_overflow)
    );

    uart_cmd_decoder #(.PULSE_CYCLES(4), .GAP_CYCLES(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .o_btn      (b_btn),
        .o_busy     (b_busy),
        .o_unknown  (b_unknown),
        .o_overflow (b_overflow)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Byte strobed at edge T; returns 1 time unit after edge T (cycle T+1)
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        $display("tx byte %h at %0t", b, $time);
    endtask

    initial begin
        rst     = 1'b0;
        sel     = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;

        // T1: reset held, strobes ignored
        step(1);
        send(8'h55);
        send(8'h52);
        check("rst_a_btn", {4'd0, a_btn}, 8'h00);
        check("rst_b_btn", {4'd0, b_btn}, 8'h00);
        check("rst_flags", {4'd0, a_busy, a_unknown, b_busy, b_overflow}, 8'h00);
        rst = 1'b1;
        step(3);
        check("post_rst_a", {a_btn, a_busy, a_unknown, a_overflow, 1'b0}, 8'h00);
        check("post_rst_b", {b_btn, b_busy, b_unknown, b_overflow, 1'b0}, 8'h00);

        // T2: default map on dut_a, each press one cycle high
        send(8'h55);
        check("t2_U_btn", {4'd0, a_btn}, 8'h08);
        check("t2_U_busy", {7'd0, a_busy}, 8'h01);
        step(1);
        check("t2_U_gap", {4'd0, a_btn}, 8'h00);
        step(1);
        check("t2_idle", {7'd0, a_busy}, 8'h00);
        send(8'h52);
        check("t2_R_btn", {4'd0, a_btn}, 8'h01);
        step(1);
        check("t2_R_off", {4'd0, a_btn}, 8'h00);
        step(1);
        send(8'h4C);
        check("t2_L_btn", {4'd0, a_btn}, 8'h02);
        step(1);
        check("t2_L_off", {4'd0, a_btn}, 8'h00);
        step(1);
        send(8'h44);
        check("t2_D_btn", {4'd0, a_btn}, 8'h04);
        step(1);
        check("t2_D_off", {4'd0, a_btn}, 8'h00);
        step(30);

        // T3: U,D,L back to back
        send(8'h55);                                   // T+1
        check("t3_b_T1", {4'd0, b_btn}, 8'h08);
        check("t3_a_T1", {4'd0, a_btn}, 8'h08);
        send(8'h44);                                   // T+2
        check("t3_b_T2", {4'd0, b_btn}, 8'h08);
        check("t3_a_T2", {4'd0, a_btn}, 8'h00);
        send(8'h4C);                                   // T+3
        check("t3_b_ovf", {7'd0, b_overflow}, 8'h01);
        check("t3_b_T3", {4'd0, b_btn}, 8'h08);
        check("t3_a_launch", {4'd0, a_btn}, 8'h04);
        check("t3_a_no_ovf", {7'd0, a_overflow}, 8'h00);
        step(1);                                       // T+4
        check("t3_b_T4", {4'd0, b_btn}, 8'h08);
        check("t3_b_ovf_clr", {7'd0, b_overflow}, 8'h00);
        check("t3_a_T4", {4'd0, a_btn}, 8'h00);
        step(1);                                       // T+5
        check("t3_b_gap1", {4'd0, b_btn}, 8'h00);
        check("t3_a_L", {4'd0, a_btn}, 8'h02);
        step(1);                                       // T+6
        check("t3_b_gap2", {4'd0, b_btn}, 8'h00);
        check("t3_b_busy", {7'd0, b_busy}, 8'h01);
        step(1);                                       // T+7
        check("t3_b_D7", {4'd0, b_btn}, 8'h04);
        step(3);                                       // T+10
        check("t3_b_D10", {4'd0, b_btn}, 8'h04);
        step(1);                                       // T+11
        check("t3_b_off", {4'd0, b_btn}, 8'h00);
        step(20);

        // T4: unknown byte, then a known byte while deselected
        send(8'h41);
        check("t4_unk_a", {7'd0, a_unknown}, 8'h01);
        check("t4_unk_b", {7'd0, b_unknown}, 8'h01);
        check("t4_unk_btn", {4'd0, a_btn}, 8'h00);
        check("t4_unk_busy", {7'd0, a_busy}, 8'h00);
        step(1);
        check("t4_unk_clr", {7'd0, a_unknown}, 8'h00);
        sel = 1'b0;
        send(8'h55);
        check("t4_nosel_a", {a_btn, a_busy, a_unknown, a_overflow, 1'b0}, 8'h00);
        check("t4_nosel_b", {b_btn, b_busy, b_unknown, b_overflow, 1'b0}, 8'h00);
        step(1);
        check("t4_nosel_a2", {4'd0, a_btn}, 8'h00);
        sel = 1'b1;
        step(5);

        // T5: U then R queued, sel drops during the pulse
        send(8'h55);                                   // T+1
        send(8'h52);                                   // T+2
        sel = 1'b0;
        step(1);                                       // T+3
        check("t5_a_flushed", {4'd0, a_btn}, 8'h00);
        check("t5_b_T3", {4'd0, b_btn}, 8'h08);
        step(1);                                       // T+4
        check("t5_b_T4", {4'd0, b_btn}, 8'h08);
        step(1);                                       // T+5
        check("t5_b_gap", {4'd0, b_btn}, 8'h00);
        check("t5_b_busy", {7'd0, b_busy}, 8'h01);
        step(2);                                       // T+7
        check("t5_b_noR", {4'd0, b_btn}, 8'h00);
        check("t5_b_idle", {7'd0, b_busy}, 8'h00);
        step(1);
        check("t5_b_noR2", {4'd0, b_btn}, 8'h00);
        sel = 1'b1;
        step(5);

        // T6: lowercase 'u'
        send(8'h75);
`ifdef UART_CMD_LOWERCASE_EN
        check("t6_lc_btn", {4'd0, a_btn}, 8'h08);
        check("t6_lc_unk", {7'd0, a_unknown}, 8'h00);
`else
        check("t6_lc_btn", {4'd0, a_btn}, 8'h00);
        check("t6_lc_unk", {7'd0, a_unknown}, 8'h01);
`endif
        step(10);

        // Asynchronous reset in the middle of a pulse
        send(8'h44);
        step(1);
        check("ar_pre", {4'd0, b_btn}, 8'h04);
        #2 rst = 1'b0;
        #1;
        check("ar_btn", {4'd0, b_btn}, 8'h00);
        check("ar_busy", {7'd0, b_busy}, 8'h00);
        step(1);
        rst = 1'b1;
        step(6);
        check("ar_after", {4'd0, b_btn}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
